// File: rtl/sign_apply.sv
`default_nettype none
// ============================================================================
// Module      : sign_apply
// Description : Sign-magnitude |a - b| via a compare/swap step followed by a
//               3-cycle bit-serial LSB-first subtraction.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_apply (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] a_mag,
  input  logic [2:0] b_mag,
  output logic       busy,
  output logic       done,
  output logic [3:0] result
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CMP  = 2'd1;
  localparam logic [1:0] c_SUB  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0] r_state;
  logic [2:0] r_x;
  logic [2:0] r_y;
  logic       r_sign;
  logic       r_borrow;
  logic [1:0] r_cnt;
  logic [2:0] r_diff;
  logic [3:0] r_result;

  logic       w_x_bit;
  logic       w_y_bit;
  logic       w_diff_bit;
  logic       w_borrow_next;

  // Operands shift right during SUB, so bit 0 is always the current bit.
  assign w_x_bit       = r_x[0];
  assign w_y_bit       = r_y[0];
  assign w_diff_bit    = w_x_bit ^ w_y_bit ^ r_borrow;
  assign w_borrow_next = (~w_x_bit & w_y_bit) | (~w_x_bit & r_borrow) | (w_y_bit & r_borrow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_x      <= 3'd0;
      r_y      <= 3'd0;
      r_sign   <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= 2'd0;
      r_diff   <= 3'd0;
      r_result <= 4'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_x     <= a_mag;
            r_y     <= b_mag;
            r_state <= c_CMP;
          end
        end
        c_CMP: begin
          // Strict compare keeps equal operands positive, so 4'b1000 never appears.
          if (r_y > r_x) begin
            r_sign <= 1'b1;
            r_x    <= r_y;
            r_y    <= r_x;
          end else begin
            r_sign <= 1'b0;
          end
          r_borrow <= 1'b0;
          r_cnt    <= 2'd0;
          r_state  <= c_SUB;
        end
        c_SUB: begin
          r_diff   <= {w_diff_bit, r_diff[2:1]};
          r_borrow <= w_borrow_next;
          r_x      <= {1'b0, r_x[2:1]};
          r_y      <= {1'b0, r_y[2:1]};
          r_cnt    <= r_cnt + 2'd1;
          if (r_cnt == 2'd2) begin
            r_result <= {r_sign, w_diff_bit, r_diff[2:1]};
            r_state  <= c_DONE;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state == c_CMP) || (r_state == c_SUB);
  assign done   = (r_state == c_DONE);
  assign result = r_result;

endmodule
`default_nettype wire
